// File: rtl/adc_capture_ctrl.sv
// Pre/post-trigger ADC capture controller: packs two samples per SDRAM word and drives the write port.
// Optional CAP_EXT_TRIG_EN adds a synchronous external trigger input (trig_ext, rising edge in ARMED).
module adc_capture_ctrl #(
   parameter int ADC_W    = 8,
   parameter int CNT_W    = 24,
   parameter int LOAD_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADC_W-1:0]     adc_data,
   input  logic                 sdram_init_done,
   input  logic                 arm,
   input  logic                 abort,
   input  logic [CNT_W-1:0]     pre_len,
   input  logic [CNT_W-1:0]     post_len,
   input  logic [ADC_W-1:0]     trig_level,
   input  logic                 trig_slope,
   input  logic                 force_trig,
`ifdef CAP_EXT_TRIG_EN
   input  logic                 trig_ext,
`endif
   output logic                 wr_en,
   output logic [2*ADC_W-1:0]   wr_data,
   output logic                 wr_load,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     trig_pos,
   output logic [2:0]           dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_PRE   = 3'd2;
   localparam logic [2:0] S_ARMED = 3'd3;
   localparam logic [2:0] S_POST  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam int         LC_W    = $clog2(LOAD_CYC + 1);

   logic [2:0]         state_q, state_d;
   logic [LC_W-1:0]    load_cnt_q, load_cnt_d;
   logic               phase_q, phase_d;
   logic [ADC_W-1:0]   hold_q, hold_d;
   logic [ADC_W-1:0]   prev_q;
   logic               wr_en_q, wr_en_d;
   logic [2*ADC_W-1:0] wr_data_q, wr_data_d;
   logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
   logic [CNT_W-1:0]   pre_len_q, pre_len_d;
   logic [CNT_W-1:0]   post_len_q, post_len_d;
   logic [CNT_W-1:0]   trig_pos_q, trig_pos_d;
   logic               packing, word_done, arm_ok, lvl_hit, ext_hit, trig_hit;

`ifdef CAP_EXT_TRIG_EN
   logic ext_prev_q;
   always_ff @(posedge clk) begin
      if (rst) ext_prev_q <= 1'b0;
      else     ext_prev_q <= trig_ext;
   end
   assign ext_hit = trig_ext & ~ext_prev_q;
`else
   assign ext_hit = 1'b0;
`endif

   assign packing   = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
   assign word_done = packing && phase_q;
   assign arm_ok    = arm && sdram_init_done && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign lvl_hit   = trig_slope ? ((prev_q >= trig_level) && (adc_data <  trig_level))
                                 : ((prev_q <  trig_level) && (adc_data >= trig_level));
   assign trig_hit  = lvl_hit || force_trig || ext_hit;

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      phase_d    = phase_q;
      hold_d     = hold_q;
      wr_en_d    = 1'b0;
      wr_data_d  = wr_data_q;
      word_cnt_d = word_cnt_q;
      post_cnt_d = post_cnt_q;
      pre_len_d  = pre_len_q;
      post_len_d = post_len_q;
      trig_pos_d = trig_pos_q;

      // Even phase holds the first sample; odd phase emits {second, first} one clock later.
      if (packing) begin
         phase_d = ~phase_q;
         if (!phase_q) begin
            hold_d = adc_data;
         end else begin
            wr_en_d    = 1'b1;
            wr_data_d  = {adc_data, hold_q};
            word_cnt_d = word_cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (arm_ok) begin
               state_d    = S_LOAD;
               load_cnt_d = '0;
               pre_len_d  = pre_len;
               post_len_d = (post_len == '0) ? CNT_W'(1) : post_len;
            end
         end
         S_LOAD: begin
            load_cnt_d = load_cnt_q + LC_W'(1);
            phase_d    = 1'b0;
            word_cnt_d = '0;
            if (load_cnt_q == LC_W'(LOAD_CYC - 1))
               state_d = (pre_len_q == '0) ? S_ARMED : S_PRE;
         end
         S_PRE: begin
            if (word_done && (word_cnt_q + CNT_W'(1) == pre_len_q))
               state_d = S_ARMED;
         end
         S_ARMED: begin
            if (trig_hit) begin
               trig_pos_d = word_cnt_q;
               // A trigger on the odd phase completes its word this cycle: that is post word 1.
               if (phase_q) begin
                  post_cnt_d = CNT_W'(1);
                  state_d    = (post_len_q == CNT_W'(1)) ? S_DONE : S_POST;
               end else begin
                  post_cnt_d = '0;
                  state_d    = S_POST;
               end
            end
         end
         S_POST: begin
            if (word_done) begin
               post_cnt_d = post_cnt_q + CNT_W'(1);
               if (post_cnt_q + CNT_W'(1) == post_len_q)
                  state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         load_cnt_q <= '0;
         phase_q    <= 1'b0;
         hold_q     <= '0;
         prev_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         word_cnt_q <= '0;
         post_cnt_q <= '0;
         pre_len_q  <= '0;
         post_len_q <= '0;
         trig_pos_q <= '0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         phase_q    <= phase_d;
         hold_q     <= hold_d;
         prev_q     <= adc_data;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         word_cnt_q <= word_cnt_d;
         post_cnt_q <= post_cnt_d;
         pre_len_q  <= pre_len_d;
         post_len_q <= post_len_d;
         trig_pos_q <= trig_pos_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_data   = wr_data_q;
   assign wr_load   = (state_q == S_LOAD);
   assign busy      = (state_q == S_LOAD) || packing;
   assign done      = (state_q == S_DONE);
   assign trig_pos  = trig_pos_q;
   assign dbg_state = state_q;

endmodule
